// File: rtl/data_mem_arbiter.sv
// Purpose : two-port round-robin arbiter/sequencer in front of the single-port data memory.
// Latency : request sampled in IDLE at t, memory strobe at t+1, ready/rdata/err at t+2.
// Backpressure: requesters hold req until their ready pulse; losers simply wait, nothing is queued.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m0_*/m1_* req/we/be/addr/wdata  master requests (port 0 = core, port 1 = loader/debug)
//   m0_*/m1_* rdata/ready/err    completion: one-cycle ready, err for out-of-range addresses
//   mem_req/we/be/addr/wdata_o   synchronous-read memory command (active only in ISSUE)
//   mem_rdata_i                  memory read data, valid the cycle after mem_req_o

package memory_pkg;
  localparam int unsigned DATA_MEM_SIZE_BYTES = 2048;
endpackage

module data_mem_arbiter #(
  parameter int unsigned DEPTH_BYTES = memory_pkg::DATA_MEM_SIZE_BYTES,
  parameter int unsigned AW          = $clog2(DEPTH_BYTES / 4)
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_be_i,
  input  logic [31:0]   m0_addr_i,
  input  logic [31:0]   m0_wdata_i,
  output logic [31:0]   m0_rdata_o,
  output logic          m0_ready_o,
  output logic          m0_err_o,

  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_be_i,
  input  logic [31:0]   m1_addr_i,
  input  logic [31:0]   m1_wdata_i,
  output logic [31:0]   m1_rdata_o,
  output logic          m1_ready_o,
  output logic          m1_err_o,

  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e      state_q;
  logic        sel_q;          // port owning the transaction in flight
  logic        we_q;           // latched direction, needed to qualify rdata in RESP
  logic        oor_q;          // latched out-of-range flag
  logic        last_grant_q;   // port granted most recently, loses the next tie

  // The memory command registers double as the latched be/addr/wdata: they are
  // loaded at grant time and presented for exactly the ISSUE cycle.
  logic          mem_req_q;
  logic          mem_we_q;
  logic [3:0]    mem_be_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;

  // Per-port completion registers, index = port number.
  logic [1:0]  ready_q;
  logic [1:0]  err_q;
  logic [1:0]  rd_pass_q;      // forward mem_rdata_i to this port during RESP

  // Grant decision for the current cycle, only meaningful in IDLE and RESP.
  logic        grant_vld_d;
  logic        grant_sel_d;

  logic        cand_we;
  logic [3:0]  cand_be;
  logic [31:0] cand_addr;
  logic [31:0] cand_wdata;
  logic        cand_oor;

  always_comb begin
    grant_vld_d = 1'b0;
    grant_sel_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_vld_d = m0_req_i | m1_req_i;
        if (m0_req_i && m1_req_i) begin
          grant_sel_d = ~last_grant_q;
        end else begin
          grant_sel_d = m1_req_i;
        end
      end
      S_RESP: begin
        // Only the opposite port may chain back-to-back; the completing port's
        // req still belongs to the transaction that is finishing now.
        grant_sel_d = ~sel_q;
        grant_vld_d = sel_q ? m0_req_i : m1_req_i;
      end
      default: begin
        grant_vld_d = 1'b0;
        grant_sel_d = 1'b0;
      end
    endcase
  end

  assign cand_we    = grant_sel_d ? m1_we_i    : m0_we_i;
  assign cand_be    = grant_sel_d ? m1_be_i    : m0_be_i;
  assign cand_addr  = grant_sel_d ? m1_addr_i  : m0_addr_i;
  assign cand_wdata = grant_sel_d ? m1_wdata_i : m0_wdata_i;
  assign cand_oor   = (cand_addr >= DEPTH_LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      oor_q        <= 1'b0;
      last_grant_q <= 1'b1;    // port 0 wins the first contention
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'b0;
      ready_q      <= 2'b0;
      err_q        <= 2'b0;
      rd_pass_q    <= 2'b0;
    end else begin
      // Every output register defaults to zero, so strobes and completion
      // pulses last exactly one cycle and nothing stale survives a state.
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'b0;
      ready_q     <= 2'b0;
      err_q       <= 2'b0;
      rd_pass_q   <= 2'b0;

      case (state_q)
        S_IDLE, S_RESP: begin
          if (grant_vld_d) begin
            sel_q        <= grant_sel_d;
            we_q         <= cand_we;
            oor_q        <= cand_oor;
            last_grant_q <= grant_sel_d;
            // Out-of-range commands never reach the memory pins.
            if (!cand_oor) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= cand_we;
              mem_be_q    <= cand_be;
              mem_addr_q  <= cand_addr[AW+1:2];
              mem_wdata_q <= cand_wdata;
            end
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_ISSUE: begin
          ready_q[sel_q]   <= 1'b1;
          err_q[sel_q]     <= oor_q;
          rd_pass_q[sel_q] <= ~oor_q & ~we_q;
          state_q          <= S_RESP;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // Read data arrives from the memory in RESP, so it is steered rather than
  // registered; the gate keeps the idle port and write completions at zero.
  assign m0_ready_o = ready_q[0];
  assign m0_err_o   = err_q[0];
  assign m0_rdata_o = rd_pass_q[0] ? mem_rdata_i : 32'b0;

  assign m1_ready_o = ready_q[1];
  assign m1_err_o   = err_q[1];
  assign m1_rdata_o = rd_pass_q[1] ? mem_rdata_i : 32'b0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Purpose : self-checking bench for data_mem_arbiter with a behavioural memory.
// Latency : checks the 2-cycle request-to-ready latency and back-to-back alternation.
// Backpressure: bench masters hold req until ready, as the arbiter expects.

module tb_data_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [8:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int n_chk;
  int n_fail;

  always #5 clk_i = ~clk_i;

  data_mem_arbiter dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m0_req_i   (m0_req_i),
    .m0_we_i    (m0_we_i),
    .m0_be_i    (m0_be_i),
    .m0_addr_i  (m0_addr_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_rdata_o (m0_rdata_o),
    .m0_ready_o (m0_ready_o),
    .m0_err_o   (m0_err_o),
    .m1_req_i   (m1_req_i),
    .m1_we_i    (m1_we_i),
    .m1_be_i    (m1_be_i),
    .m1_addr_i  (m1_addr_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_rdata_o (m1_rdata_o),
    .m1_ready_o (m1_ready_o),
    .m1_err_o   (m1_err_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_be_o   (mem_be_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // Synchronous-read memory that the arbiter drives.
  logic [31:0] tb_mem [512];
  logic        mem_init;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)   return 32'hDEADBEEF;
    if (i == 511) return 32'hAAAAAAAA;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) tb_mem[i] <= init_word(i);
      mem_rdata_i <= 32'b0;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) tb_mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= tb_mem[mem_addr_o];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req_i = req; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wdata_i = wdata;
    end else begin
      m1_req_i = req; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wdata_i = wdata;
    end
  endtask

  function automatic logic get_rdy(input int p);
    return (p == 0) ? m0_ready_o : m1_ready_o;
  endfunction
  function automatic logic get_err(input int p);
    return (p == 0) ? m0_err_o : m1_err_o;
  endfunction
  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? m0_rdata_o : m1_rdata_o;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_m0_ready"}, 32'(m0_ready_o), 0);
    chk({tag, "_m1_ready"}, 32'(m1_ready_o), 0);
    chk({tag, "_m0_err"},   32'(m0_err_o), 0);
    chk({tag, "_m1_err"},   32'(m1_err_o), 0);
    chk({tag, "_m0_rdata"}, m0_rdata_o, 0);
    chk({tag, "_m1_rdata"}, m1_rdata_o, 0);
    chk({tag, "_mem_req"},  32'(mem_req_o), 0);
    chk({tag, "_mem_we"},   32'(mem_we_o), 0);
    chk({tag, "_mem_be"},   32'(mem_be_o), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr_o), 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
  endtask

  task automatic reset_dut();
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_port(1, 0, 0, 4'h0, 32'h0, 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [8:0]  exp_word;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Called at a negedge with the arbiter idle; returns at a negedge, idle again.
  task automatic run_single(input vec_t v, input string tag);
    int o;
    o = 1 - v.port;
    set_port(v.port, 1, v.we, v.be, v.addr, v.wdata);
    @(negedge clk_i);  // t+1: ISSUE
    chk({tag, "_t1_mem_req"},   32'(mem_req_o), 32'(!v.exp_err));
    chk({tag, "_t1_mem_we"},    32'(mem_we_o),   v.exp_err ? 32'd0 : 32'(v.we));
    chk({tag, "_t1_mem_be"},    32'(mem_be_o),   v.exp_err ? 32'd0 : 32'(v.be));
    chk({tag, "_t1_mem_addr"},  32'(mem_addr_o), v.exp_err ? 32'd0 : 32'(v.exp_word));
    chk({tag, "_t1_mem_wdata"}, mem_wdata_o,     v.exp_err ? 32'd0 : v.wdata);
    chk({tag, "_t1_ready"},     32'(get_rdy(v.port)), 0);
    @(negedge clk_i);  // t+2: RESP
    chk({tag, "_t2_ready"},       32'(get_rdy(v.port)), 1);
    chk({tag, "_t2_rdata"},       get_rdata(v.port), v.exp_rdata);
    chk({tag, "_t2_err"},         32'(get_err(v.port)), 32'(v.exp_err));
    chk({tag, "_t2_other_ready"}, 32'(get_rdy(o)), 0);
    chk({tag, "_t2_other_err"},   32'(get_err(o)), 0);
    chk({tag, "_t2_other_rdata"}, get_rdata(o), 0);
    chk({tag, "_t2_mem_req"},     32'(mem_req_o), 0);
    set_port(v.port, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);  // t+3: back in IDLE
    chk({tag, "_t3_ready"},   32'(get_rdy(v.port)), 0);
    chk({tag, "_t3_mem_req"}, 32'(mem_req_o), 0);
  endtask

  // Transaction-level reference state for the randomized phase.
  logic [31:0] ref_mem [512];
  bit          pend [2];
  int          waitc [2];
  int          gap [2];
  int          n_done [2];
  logic        cur_we [2];
  logic [3:0]  cur_be [2];
  logic [31:0] cur_addr [2];
  logic [31:0] cur_wdata [2];
  int          acc_cnt;
  logic [8:0]  acc_word;
  logic        acc_we;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  int          last_done;
  bit          waited_last;

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return ($urandom_range(0, 15) * 4) | $urandom_range(0, 3);
    if (r == 7) return 32'h7FC;
    if (r == 8) return 32'h800 + $urandom_range(0, 255);
    return $urandom() | 32'h8000_0000;
  endfunction

  vec_t vecs [9];
  vec_t v_after_rst;

  initial begin
    n_chk = 0;
    n_fail = 0;

    vecs[0] = '{port:0, we:0, be:4'hF, addr:32'h10,       wdata:32'h0,        exp_word:9'd4,   exp_rdata:32'hDEADBEEF, exp_err:0};
    vecs[1] = '{port:1, we:1, be:4'h3, addr:32'h7FC,      wdata:32'h12345678, exp_word:9'd511, exp_rdata:32'h0,        exp_err:0};
    vecs[2] = '{port:0, we:0, be:4'hF, addr:32'h7FC,      wdata:32'h0,        exp_word:9'd511, exp_rdata:32'hAAAA5678, exp_err:0};
    vecs[3] = '{port:0, we:0, be:4'hF, addr:32'h800,      wdata:32'h0,        exp_word:9'd0,   exp_rdata:32'h0,        exp_err:1};
    vecs[4] = '{port:1, we:1, be:4'hC, addr:32'h11,       wdata:32'hCAFEF00D, exp_word:9'd4,   exp_rdata:32'h0,        exp_err:0};
    vecs[5] = '{port:1, we:0, be:4'h5, addr:32'h13,       wdata:32'h0,        exp_word:9'd4,   exp_rdata:32'hCAFEBEEF, exp_err:0};
    vecs[6] = '{port:1, we:0, be:4'hF, addr:32'hFFFFFFFC, wdata:32'h0,        exp_word:9'd0,   exp_rdata:32'h0,        exp_err:1};
    vecs[7] = '{port:0, we:1, be:4'hF, addr:32'h1000,     wdata:32'h1,        exp_word:9'd0,   exp_rdata:32'h0,        exp_err:1};
    vecs[8] = '{port:0, we:0, be:4'hF, addr:32'h3C,       wdata:32'h0,        exp_word:9'd15,  exp_rdata:32'hC0DE000F, exp_err:0};
    v_after_rst = '{port:1, we:0, be:4'hF, addr:32'h0,    wdata:32'h0,        exp_word:9'd0,   exp_rdata:32'hC0DE0000, exp_err:0};

    // Reset state
    mem_init = 1'b1;
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_port(1, 0, 0, 4'h0, 32'h0, 32'h0);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    mem_init = 1'b0;
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Reset pulsed in the ISSUE cycle of a write
    set_port(0, 1, 1, 4'hF, 32'h190, 32'h5555AAAA);
    @(negedge clk_i);
    chk("rstmid_issue_mem_req", 32'(mem_req_o), 1);
    rst_i = 1'b1;
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check_all_zero("rstmid_after");
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("rstmid_no_ready_m0", 32'(m0_ready_o), 0);
      chk("rstmid_no_ready_m1", 32'(m1_ready_o), 0);
      chk("rstmid_mem_req",     32'(mem_req_o), 0);
    end
    run_single(v_after_rst, "rstmid_recover");

    // Table of single-requester transactions
    for (int i = 0; i < 9; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Both ports contend from reset and hold req
    reset_dut();
    set_port(0, 1, 0, 4'hF, 32'h10, 32'h0);
    set_port(1, 1, 0, 4'hF, 32'h14, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      chk($sformatf("rr_c%0d_m0_ready", c), 32'(m0_ready_o), 32'(c == 2 || c == 6));
      chk($sformatf("rr_c%0d_m1_ready", c), 32'(m1_ready_o), 32'(c == 4 || c == 8));
      if (c == 2 || c == 6) chk($sformatf("rr_c%0d_m0_rdata", c), m0_rdata_o, 32'hCAFEBEEF);
      if (c == 4 || c == 8) chk($sformatf("rr_c%0d_m1_rdata", c), m1_rdata_o, 32'hC0DE0005);
      if (c == 8) begin
        set_port(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_port(1, 0, 0, 4'h0, 32'h0, 32'h0);
      end
    end
    @(negedge clk_i);
    chk("rr_end_mem_req", 32'(mem_req_o), 0);
    chk("rr_end_m0_ready", 32'(m0_ready_o), 0);

    // Port 0 keeps req high through RESP with port 1 idle
    set_port(0, 1, 0, 4'hF, 32'h14, 32'h0);
    @(negedge clk_i);
    chk("hold_t1_mem_req", 32'(mem_req_o), 1);
    @(negedge clk_i);
    chk("hold_t2_ready", 32'(m0_ready_o), 1);
    @(negedge clk_i);
    chk("hold_t3_mem_req", 32'(mem_req_o), 0);
    chk("hold_t3_ready",   32'(m0_ready_o), 0);
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("hold_t4_mem_req", 32'(mem_req_o), 0);
    @(negedge clk_i);
    chk("hold_t5_ready", 32'(m0_ready_o), 0);

    // Randomized traffic from both ports against the transaction-level model
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    ref_mem[4]   = 32'hCAFEBEEF;
    ref_mem[511] = 32'hAAAA5678;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; waitc[k] = 0; gap[k] = 0; n_done[k] = 0;
    end
    acc_cnt = 0;
    last_done = -1;
    waited_last = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        acc_cnt++;
        acc_word = mem_addr_o; acc_we = mem_we_o; acc_be = mem_be_o; acc_wdata = mem_wdata_o;
      end
      chk("rnd_both_ready", 32'(m0_ready_o & m1_ready_o), 0);
      for (int k = 0; k < 2; k++) begin
        logic        oor;
        logic [8:0]  word;
        logic [31:0] exp_rd;
        if (!get_rdy(k)) begin
          chk($sformatf("rnd_idle_err_p%0d", k),   32'(get_err(k)), 0);
          chk($sformatf("rnd_idle_rdata_p%0d", k), get_rdata(k), 0);
        end else begin
          chk($sformatf("rnd_ready_had_req_p%0d", k), 32'(pend[k]), 1);
          if (pend[k]) begin
            oor    = (cur_addr[k] >= 32'd2048);
            word   = cur_addr[k][10:2];
            exp_rd = (!oor && !cur_we[k]) ? ref_mem[word] : 32'h0;
            chk($sformatf("rnd_err_p%0d", k),   32'(get_err(k)), 32'(oor));
            chk($sformatf("rnd_rdata_p%0d", k), get_rdata(k), exp_rd);
            chk($sformatf("rnd_mem_accesses_p%0d", k), 32'(acc_cnt), oor ? 32'd0 : 32'd1);
            if (!oor) begin
              chk($sformatf("rnd_mem_word_p%0d", k), 32'(acc_word), 32'(word));
              chk($sformatf("rnd_mem_we_p%0d", k),   32'(acc_we), 32'(cur_we[k]));
              if (cur_we[k]) begin
                chk($sformatf("rnd_mem_be_p%0d", k),    32'(acc_be), 32'(cur_be[k]));
                chk($sformatf("rnd_mem_wdata_p%0d", k), acc_wdata, cur_wdata[k]);
                for (int b = 0; b < 4; b++)
                  if (cur_be[k][b]) ref_mem[word][8*b +: 8] = cur_wdata[k][8*b +: 8];
              end
            end
            if (last_done >= 0 && waited_last) chk("rnd_rr_alternate", 32'(k), 32'(1 - last_done));
            last_done   = k;
            waited_last = pend[1 - k];
            n_done[k]++;
          end
          pend[k] = 0;
          gap[k]  = 1 + $urandom_range(0, 2);
          acc_cnt = 0;
          set_port(k, 0, 0, 4'h0, 32'h0, 32'h0);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (pend[k]) begin
          waitc[k]++;
          if (waitc[k] > 10) begin
            n_chk++;
            n_fail++;
            $display("FAIL rnd_timeout_p%0d: no ready after %0d cycles, required within 10", k, waitc[k]);
            pend[k] = 0;
            gap[k]  = 2;
            set_port(k, 0, 0, 4'h0, 32'h0, 32'h0);
          end
        end else if (gap[k] > 0) begin
          gap[k]--;
        end else if ($urandom_range(0, 2) != 0) begin
          cur_we[k]    = 1'($urandom_range(0, 1));
          cur_be[k]    = 4'($urandom_range(0, 15));
          cur_addr[k]  = rand_addr();
          cur_wdata[k] = $urandom();
          pend[k]      = 1;
          waitc[k]     = 0;
          set_port(k, 1, cur_we[k], cur_be[k], cur_addr[k], cur_wdata[k]);
        end
      end
    end
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_port(1, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("rnd_p0_served", 32'(n_done[0] > 50), 1);
    chk("rnd_p1_served", 32'(n_done[1] > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
